// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet front-end blocks.
//   feed_state_e : column feeder phase (FILL while priming line buffers,
//                  STREAM once four rows are buffered)
//   KERNEL       : convolution window height/width
//   CHANNELS     : colour channels carried per pixel
package lenet_pkg;

  localparam int KERNEL   = 5;
  localparam int CHANNELS = 3;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } feed_state_e;

endpackage

// File: rtl/line_buf_ram.sv
// One image line of pixels: a single synchronous write port and an
// asynchronous (combinational) read port. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write column
//   wdata_i : pixel written
//   raddr_i : read column
//   rdata_o : pixel stored at raddr_i
module line_buf_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/col_feeder553.sv
// Column feeder for a 5x5 convolver. Accepts raster-order pixels, keeps the
// previous four lines in rotating line buffers and, once four rows are
// buffered, presents one 5-row column per accepted pixel on a valid/ready
// output.
//
// Optional feature: define COL_FEEDER_STALL_CNT_EN to add the stall_cnt
// output (cycles with out_valid=1 and out_ready=0, saturating).
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : in_pix valid
//   in_ready   : pixel accepted this cycle when in_valid is high
//   in_pix     : pixel, channel 0 in the low slice
//   col0..2    : 5-row column per channel, low slice = row r-4, top = row r
//   out_valid  : cols hold an unconsumed column
//   out_ready  : downstream consumes the column
//   out_en     : out_valid & out_ready (convolver enable)
//   win_valid  : presented column completes a full 5x5 window
//   frame_done : one-cycle pulse after the last pixel of a frame
//   stall_cnt  : (optional) saturating stall counter
//
// state  | meaning
// FILL   | rows 0..3: pixels only written to the line buffers
// STREAM | rows 4..IMG_H-1: each accepted pixel produces a column
module col_feeder553
  import lenet_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*BIT_WIDTH-1:0] in_pix,
  output logic [KERNEL*BIT_WIDTH-1:0]   col0,
  output logic [KERNEL*BIT_WIDTH-1:0]   col1,
  output logic [KERNEL*BIT_WIDTH-1:0]   col2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_en,
  output logic                          win_valid,
  output logic                          frame_done
`ifdef COL_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int PW   = CHANNELS * BIT_WIDTH;
  localparam int CLW  = KERNEL * BIT_WIDTH;
  localparam int NBUF = KERNEL - 1;
  localparam int PTRW = $clog2(NBUF);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  localparam logic [CW-1:0] C_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_WIN       = CW'(KERNEL - 1);
  localparam logic [RW-1:0] R_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_FILL_LAST = RW'(KERNEL - 2);

  feed_state_e     state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic            ov_q, ov_d;
  logic            win_q, win_d;
  logic            fd_q, fd_d;
  logic [CLW-1:0]  col_q [CHANNELS];
  logic [CLW-1:0]  col_d [CHANNELS];
  logic [CLW-1:0]  col_new [CHANNELS];
  logic [PW-1:0]   rd [NBUF];

  logic accept;
  logic row_end;
  logic frame_end;

  assign in_ready  = (state_q == FILL) || !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign row_end   = accept && (c_q == C_LAST);
  assign frame_end = row_end && (r_q == R_LAST);

  // wptr_q names the buffer holding the oldest row (r-4); that buffer is
  // read and overwritten at the same column in the same cycle, so the
  // asynchronous read still sees row r-4 when the column is assembled.
  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    line_buf_ram #(
      .DEPTH (IMG_W),
      .WIDTH (PW),
      .AW    (CW)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (accept && (wptr_q == PTRW'(b))),
      .waddr_i (c_q),
      .wdata_i (in_pix),
      .raddr_i (c_q),
      .rdata_o (rd[b])
    );
  end

  // Column assembly: oldest buffered row at the bottom slice, newest
  // buffered row just below the incoming pixel.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      col_new[ch] = '0;
      for (int k = 0; k < NBUF; k++) begin
        col_new[ch][k*BIT_WIDTH +: BIT_WIDTH] =
          rd[PTRW'(wptr_q + PTRW'(k))][ch*BIT_WIDTH +: BIT_WIDTH];
      end
      col_new[ch][NBUF*BIT_WIDTH +: BIT_WIDTH] = in_pix[ch*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    wptr_d  = wptr_q;
    ov_d    = ov_q;
    win_d   = win_q;
    fd_d    = frame_end;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      col_d[ch] = col_q[ch];
    end

    if (accept) begin
      c_d = row_end ? '0 : c_q + 1'b1;
      if (row_end) begin
        wptr_d = wptr_q + 1'b1;
        r_d    = frame_end ? '0 : r_q + 1'b1;
      end
    end

    case (state_q)
      FILL:    if (row_end && (r_q == R_FILL_LAST)) state_d = STREAM;
      STREAM:  if (frame_end) state_d = FILL;
      default: state_d = FILL;
    endcase

    // A new column may replace a consumed one in the same cycle, so the
    // load takes priority over the clear and out_valid never bubbles.
    if (accept && (state_q == STREAM)) begin
      ov_d  = 1'b1;
      win_d = (c_q >= C_WIN);
      for (int ch = 0; ch < CHANNELS; ch++) begin
        col_d[ch] = col_new[ch];
      end
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      c_q     <= '0;
      r_q     <= '0;
      wptr_q  <= '0;
      ov_q    <= 1'b0;
      win_q   <= 1'b0;
      fd_q    <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        col_q[ch] <= '0;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      wptr_q  <= wptr_d;
      ov_q    <= ov_d;
      win_q   <= win_d;
      fd_q    <= fd_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        col_q[ch] <= col_d[ch];
      end
    end
  end

  assign col0       = col_q[0];
  assign col1       = col_q[1];
  assign col2       = col_q[2];
  assign out_valid  = ov_q;
  assign out_en     = ov_q && out_ready;
  assign win_valid  = win_q;
  assign frame_done = fd_q;

`ifdef COL_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (ov_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_col_feeder553.sv
module tb_col_feeder553;

  localparam int BW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic [39:0] col0, col1, col2;
  logic        out_valid;
  logic        out_ready;
  logic        out_en;
  logic        win_valid;
  logic        frame_done;
`ifdef COL_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  col_feeder553 #(
    .BIT_WIDTH (BW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .col0       (col0),
    .col1       (col1),
    .col2       (col2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_en     (out_en),
    .win_valid  (win_valid),
    .frame_done (frame_done)
`ifdef COL_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the current frame as an image, position of the next
  // pixel, and the column that should be on the output
  logic [23:0] img [H][W];
  int          mr, mc, cyc;
  bit          exp_ov, exp_win, exp_fd;
  logic [39:0] exp_col [3];
  logic [31:0] exp_stall;
  logic [23:0] cur_pix;
  int          pix_mode;

  // observations of the DUT, checked against constants after each phase
  int          n_en, n_fd, n_ov, n_irlo;
  int          first_en_cyc, first_win_idx, acc40_cyc;
  logic [39:0] first_col0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_pix();
    if (pix_mode == 0) cur_pix = {3{8'(mr * 8 + mc)}};
    else               cur_pix = 24'($urandom);
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_ov = 0; exp_win = 0; exp_fd = 0;
    for (int ch = 0; ch < 3; ch++) exp_col[ch] = '0;
    exp_stall = '0;
    new_pix();
  endtask

  task automatic clear_obs();
    n_en = 0; n_fd = 0; n_ov = 0; n_irlo = 0;
    first_en_cyc = -1; first_win_idx = -1; acc40_cyc = -100;
    first_col0 = '0;
  endtask

  task automatic step(input bit v, input bit rdy);
    bit exp_ir, acc, cons;
    in_valid  = v;
    out_ready = rdy;
    in_pix    = cur_pix;
    @(negedge clk);
    exp_ir = (mr < 4) ? 1'b1 : (!exp_ov || rdy);
    check("in_ready",   64'(in_ready),   64'(exp_ir));
    check("out_valid",  64'(out_valid),  64'(exp_ov));
    check("out_en",     64'(out_en),     64'(exp_ov && rdy));
    check("frame_done", 64'(frame_done), 64'(exp_fd));
    if (exp_ov) begin
      check("col0",      64'(col0),      64'(exp_col[0]));
      check("col1",      64'(col1),      64'(exp_col[1]));
      check("col2",      64'(col2),      64'(exp_col[2]));
      check("win_valid", 64'(win_valid), 64'(exp_win));
    end
`ifdef COL_FEEDER_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    if (out_en) begin
      if (n_en == 0) begin
        first_en_cyc = cyc;
        first_col0   = col0;
      end
      if (win_valid && first_win_idx < 0) first_win_idx = n_en;
      n_en++;
    end
    if (out_valid)  n_ov++;
    if (frame_done) n_fd++;
    if (!in_ready)  n_irlo++;

    @(posedge clk);
    acc  = v && exp_ir;
    cons = exp_ov && rdy;
    if (exp_ov && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    exp_fd = 0;
    if (acc) begin
      img[mr][mc] = cur_pix;
      if (mr >= 4) begin
        exp_ov  = 1;
        exp_win = (mc >= 4);
        for (int ch = 0; ch < 3; ch++)
          for (int k = 0; k < 5; k++)
            exp_col[ch][k*8 +: 8] = img[mr-4+k][mc][ch*8 +: 8];
        if (mr == 4 && mc == 0) acc40_cyc = cyc;
      end else if (cons) begin
        exp_ov = 0;
      end
      if (mc == W - 1) begin
        mc = 0;
        if (mr == H - 1) begin
          mr = 0;
          exp_fd = 1;
        end else begin
          mr++;
        end
      end else begin
        mc++;
      end
      new_pix();
    end else if (cons) begin
      exp_ov = 0;
    end
    cyc++;
    #1;
  endtask

  // rmode 0: full throughput, 1: 5-cycle out_ready stall mid-row 4,
  // 2: random in_valid/out_ready
  task automatic run_frame(input int rmode);
    int guard, stall_left;
    bit stalled, v, rdy;
    guard = 0; stall_left = 0; stalled = 0;
    do begin
      v = 1; rdy = 1;
      case (rmode)
        1: begin
          if (!stalled && mr == 4 && mc == 3) begin
            stall_left = 5;
            stalled    = 1;
          end
          rdy = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: begin
          v   = ($urandom_range(0, 3) != 0);
          rdy = ($urandom_range(0, 4) > 1);
        end
        default: ;
      endcase
      step(v, rdy);
      guard++;
    end while (!exp_fd && guard < 2000);
    if (!exp_fd) begin
      n_tests++;
      n_fail++;
      $error("FAIL frame_timeout observed=%0d cycles expected=frame end", guard);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'(1));
    check({tag, "_out_valid"},  64'(out_valid),  64'(0));
    check({tag, "_out_en"},     64'(out_en),     64'(0));
    check({tag, "_win_valid"},  64'(win_valid),  64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_col0"},       64'(col0),       64'(0));
    check({tag, "_col1"},       64'(col1),       64'(0));
    check({tag, "_col2"},       64'(col2),       64'(0));
`ifdef COL_FEEDER_STALL_CNT_EN
    check({tag, "_stall_cnt"},  64'(stall_cnt),  64'(0));
`endif
  endtask

  task automatic ramp_frame(input string tag);
    pix_mode = 0;
    new_pix();
    clear_obs();
    run_frame(0);
    step(0, 1);
    check({tag, "_en_total"},  64'(n_en), 64'(16));
    check({tag, "_fd_count"},  64'(n_fd), 64'(1));
    check({tag, "_ov_cycles"}, 64'(n_ov), 64'(16));
    check({tag, "_first_col0"}, 64'(first_col0), 64'(40'h20_18_10_08_00));
    check({tag, "_first_en_lat"}, 64'(first_en_cyc - acc40_cyc), 64'(1));
    check({tag, "_first_win_idx"}, 64'(first_win_idx), 64'(4));
  endtask

  initial begin
    int g;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pix = '0;
    cyc = 0; pix_mode = 0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // first frame, ramp pixels, downstream always ready
    ramp_frame("ramp1");

    // two back-to-back frames of random pixels at full throughput
    pix_mode = 1;
    new_pix();
    clear_obs();
    run_frame(0);
    run_frame(0);
    step(0, 1);
    check("b2b_en_total",  64'(n_en), 64'(32));
    check("b2b_fd_count",  64'(n_fd), 64'(2));
    check("b2b_ov_cycles", 64'(n_ov), 64'(32));

    // 5-cycle downstream stall in the middle of row 4
    clear_obs();
    run_frame(1);
    step(0, 1);
    check("stall_en_total", 64'(n_en),   64'(16));
    check("stall_ir_low",   64'(n_irlo), 64'(5));
`ifdef COL_FEEDER_STALL_CNT_EN
    check("stall_cnt_5", 64'(stall_cnt), 64'(5));
`endif

    // random handshakes on both sides
    clear_obs();
    run_frame(2);
    step(0, 1);
    g = 0;
    while (exp_ov && g < 20) begin
      step(0, 1);
      g++;
    end
    check("rand_en_total", 64'(n_en), 64'(16));
    check("rand_fd_count", 64'(n_fd), 64'(1));

    // reset while pixel (4,3) is being presented
    pix_mode = 0;
    new_pix();
    g = 0;
    while (!(mr == 4 && mc == 3) && g < 500) begin
      step(1, 1);
      g++;
    end
    rst = 1'b0;
    #1;
    model_reset();
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    ramp_frame("ramp2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/col_feeder553.md
COL_FEEDER553 -- requirements
Module: col_feeder553

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, meaning pixel width per channel.
REQ-002 SHALL have parameter IMG_W, default 32, meaning image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 32, meaning image height in rows.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning in_pix is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_pix this cycle.
REQ-008 SHALL have port in_pix, input, 3*BIT_WIDTH, meaning one raster-order pixel; [BIT_WIDTH-1:0] is channel 0.
REQ-009 SHALL have ports col0, col1, col2, output, 5*BIT_WIDTH each, meaning the 5-row column for channels 0/1/2; [BIT_WIDTH-1:0] is the top row (r-4), the top slice is row r.
REQ-010 SHALL have port out_valid, output, 1, meaning the cols hold an unconsumed column.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream consumes the column.
REQ-012 SHALL have port out_en, output, 1, meaning out_valid AND out_ready; drives the convolver's en.
REQ-013 SHALL have port win_valid, output, 1, meaning the presented column completes a full 5x5 window (column index >= 4).
REQ-014 SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last frame pixel is accepted.

Function
REQ-015 SHALL keep a column counter c (0..IMG_W-1) and a row counter r (0..IMG_H-1), advanced on each accepted pixel (in_valid AND in_ready); c wraps to 0 and increments r.
REQ-016 SHALL implement state FILL (r<4): in_ready=1, pixels are only written to the line buffers, out_valid stays 0.
REQ-017 SHALL implement state STREAM (r>=4): in_ready = !out_valid OR out_ready; an accepted pixel loads cols with the 4 buffered rows at column c plus in_pix, and sets out_valid on the next cycle (latency 1).
REQ-018 SHALL transition FILL->STREAM when pixel (3, IMG_W-1) is accepted, and STREAM->FILL when pixel (IMG_H-1, IMG_W-1) is accepted.
REQ-019 SHALL hold cols and win_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, when a column is consumed and a new pixel is accepted in the same cycle, load the new column with out_valid remaining 1 (no bubble).
REQ-021 SHALL clear out_valid after consumption when no new pixel is accepted.
REQ-022 SHALL register win_valid with the column as (c >= 4) of the pixel that produced it.
REQ-023 SHALL store 4 lines in rotating storage (write pointer advances per row, no data shifting); the newest buffered line sits just below in_pix in the column.
REQ-024 SHALL pulse frame_done one cycle after the final pixel; the next frame starts in FILL with r=c=0 and stale buffer contents overwritten.

Reset
REQ-025 SHALL, on rst low, clear r, c, the line pointer, out_valid, win_valid and frame_done to 0, and set state to FILL, regardless of any frame in progress.
REQ-026 SHALL reset cols to 0; line buffer contents are not reset.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with COL_FEEDER_STALL_CNT_EN defined, add output stall_cnt (32 bits, reset 0), incremented every cycle out_valid=1 and out_ready=0, saturating at all-ones.
REQ-029 SHALL, without COL_FEEDER_STALL_CNT_EN, have no stall_cnt port and no counter logic.

Structure
REQ-030 SHALL place the state enum (FILL, STREAM) and the constants KERNEL=5 and CHANNELS=3 in the shared lenet package.
REQ-031 SHALL use one sub-module line_buf_ram: IMG_W x (3*BIT_WIDTH), one write port and an asynchronous read port; four instances.

Verification
REQ-032 SHALL cover the first frame with out_ready=1, IMG_W=8, IMG_H=6, pixel value = r*8+c on all channels: first out_en follows pixel (4,0); col0 = {32,24,16,8,0}, top slice first; win_valid first high for (4,4); 16 out_en total.
REQ-033 SHALL cover holding out_ready=0 for 5 cycles mid-row: in_ready=0, cols and win_valid stable, no pixel lost, and stall_cnt=5 when the macro is defined.
REQ-034 SHALL cover a simultaneous consume and accept on every cycle: out_valid stays 1 continuously and no bubbles appear.
REQ-035 SHALL cover two back-to-back frames: a single frame_done pulse after pixel (5,7), and the second frame's first column contains no first-frame data in row 4.
REQ-036 SHALL cover rst asserted at pixel (4,3): all outputs reach their reset values immediately, and a new frame is handled as in REQ-032.
